// File: rtl/tcdm_interleaved_bank.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_interleaved_bank
// Description : Single word-interleaved TCDM bank behind the L2 crossbar.
//               Zero-initialises its flop array after reset/clear, then
//               answers every granted request exactly one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_interleaved_bank #(
    parameter int unsigned CFI_DATA_WIDTH = 32,
    parameter int unsigned NR_BANKS       = 4,
    parameter int unsigned BANK_WORDS     = 64,
    parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      req_i,
    input  logic [31:0]               add_i,
    input  logic                      wen_i,
    input  logic [3:0]                be_i,
    input  logic [CFI_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [CFI_DATA_WIDTH-1:0] r_rdata_o,
    output logic                      r_opc_o,
    output logic                      init_done_o
);

    localparam int unsigned c_NB_LOG = $clog2(NR_BANKS);
    localparam int unsigned c_BW_LOG = $clog2(BANK_WORDS);
    localparam logic [31:0] c_RANGE  = 32'(NR_BANKS * BANK_WORDS * 4);
    localparam logic [c_BW_LOG-1:0] c_LAST_WORD = c_BW_LOG'(BANK_WORDS - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                    r_state;
    logic [c_BW_LOG-1:0]       r_cnt;
    logic [CFI_DATA_WIDTH-1:0] r_mem [BANK_WORDS];

    logic [31:0]               w_off;
    logic                      w_in_range;
    logic [c_BW_LOG-1:0]       w_idx;
    logic                      w_accept;
    logic                      w_do_write;
    logic [CFI_DATA_WIDTH-1:0] w_wmask;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
    assign w_off      = add_i - BASE_ADDR;
    assign w_in_range = (w_off < c_RANGE);
    assign w_idx      = w_off[2+c_NB_LOG +: c_BW_LOG];

    assign gnt_o       = req_i && (r_state == ST_READY);
    assign init_done_o = (r_state == ST_READY);
    assign w_accept    = gnt_o;
    assign w_do_write  = w_accept && !wen_i && w_in_range;

    always_comb begin
        w_wmask = '0;
        for (int k = 0; k < 4; k++) begin
            w_wmask[8*k +: 8] = {8{be_i[k]}};
        end
        // Bits beyond the first word follow the OR of all byte enables.
        for (int i = 32; i < CFI_DATA_WIDTH; i++) begin
            w_wmask[i] = |be_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + c_BW_LOG'(1);
                    if (r_cnt == c_LAST_WORD) begin
                        r_state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (clear_i) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Storage carries no reset; INIT sweeps it to zero before any grant.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_do_write) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (wdata_i & w_wmask);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_o <= 1'b0;
            r_rdata_o <= '0;
            r_opc_o   <= 1'b0;
        end else begin
            r_valid_o <= w_accept;
            if (w_accept) begin
                r_opc_o   <= !w_in_range;
                r_rdata_o <= (wen_i && w_in_range) ? r_mem[w_idx] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_interleaved_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_interleaved_bank
// Description : Directed self-checking bench for tcdm_interleaved_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_interleaved_bank;

    localparam logic [31:0] c_BASE = 32'h1C00_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        req_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic        r_opc_o;
    logic        init_done_o;

    int errors = 0;
    int checks = 0;

    tcdm_interleaved_bank #(
        .CFI_DATA_WIDTH (32),
        .NR_BANKS       (4),
        .BANK_WORDS     (64),
        .BASE_ADDR      (c_BASE)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .req_i       (req_i),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .r_opc_o     (r_opc_o),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; issues one request and checks its grant and response.
    task automatic xfer(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_opc);
        req_i   = 1'b1;
        wen_i   = wen;
        add_i   = addr;
        be_i    = be;
        wdata_i = wd;
        #1;
        check_eq({tag, ".gnt"}, 64'(gnt_o), 64'd1);
        @(negedge clk_i);
        req_i = 1'b0;
        check_eq({tag, ".valid"}, 64'(r_valid_o), 64'd1);
        check_eq({tag, ".rdata"}, 64'(r_rdata_o), 64'(exp_rd));
        check_eq({tag, ".opc"},   64'(r_opc_o),   64'(exp_opc));
    endtask

    // Holds a read request through INIT and counts cycles until READY.
    task automatic wait_init(input string tag, input int exp_cycles);
        int n = 0;
        int bad_gnt = 0;
        int bad_val = 0;
        req_i = 1'b1;
        wen_i = 1'b1;
        add_i = c_BASE;
        be_i  = 4'hF;
        #1;
        while (!init_done_o && n < 200) begin
            if (gnt_o) bad_gnt++;
            @(negedge clk_i);
            n++;
            if (r_valid_o) bad_val++;
        end
        req_i = 1'b0;
        check_eq({tag, ".init_cycles"}, 64'(n), 64'(exp_cycles));
        check_eq({tag, ".gnt_in_init"}, 64'(bad_gnt), 64'd0);
        check_eq({tag, ".valid_in_init"}, 64'(bad_val), 64'd0);
    endtask

    initial begin
        logic [31:0] last_wd;
        int gnts;
        int vals;

        rst_ni  = 1'b0;
        clear_i = 1'b0;
        req_i   = 1'b1;
        add_i   = c_BASE;
        wen_i   = 1'b1;
        be_i    = 4'hF;
        wdata_i = '0;
        repeat (2) @(negedge clk_i);
        check_eq("rst.gnt",   64'(gnt_o),       64'd0);
        check_eq("rst.valid", 64'(r_valid_o),   64'd0);
        check_eq("rst.rdata", 64'(r_rdata_o),   64'd0);
        check_eq("rst.opc",   64'(r_opc_o),     64'd0);
        check_eq("rst.done",  64'(init_done_o), 64'd0);
        rst_ni = 1'b1;
        wait_init("init0", 64);

        xfer("rd_zero", 1'b1, c_BASE + 32'h20, 4'hF, 32'h0, 32'h0, 1'b0);
        xfer("wr_full", 1'b0, c_BASE + 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer("wr_byte", 1'b0, c_BASE + 32'h10, 4'b0001, 32'h000000AA, 32'h0, 1'b0);
        xfer("rd_merge", 1'b1, c_BASE + 32'h10, 4'hF, 32'h0, 32'hDEADBEAA, 1'b0);
        // Bank-select and byte-offset bits do not change the word index.
        xfer("rd_alias", 1'b1, c_BASE + 32'h17, 4'hF, 32'h0, 32'hDEADBEAA, 1'b0);
        xfer("wr_be0", 1'b0, c_BASE + 32'h10, 4'h0, 32'h0, 32'h0, 1'b0);
        xfer("rd_be0", 1'b1, c_BASE + 32'h10, 4'hF, 32'h0, 32'hDEADBEAA, 1'b0);

        xfer("rd_below", 1'b1, c_BASE - 32'h4, 4'hF, 32'h0, 32'h0, 1'b1);
        xfer("rd_above", 1'b1, c_BASE + 32'h400, 4'hF, 32'h0, 32'h0, 1'b1);
        xfer("wr_above", 1'b0, c_BASE + 32'h400, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
        xfer("rd_word0", 1'b1, c_BASE, 4'hF, 32'h0, 32'h0, 1'b0);
        xfer("wr_last", 1'b0, c_BASE + 32'h3FC, 4'hF, 32'h11223344, 32'h0, 1'b0);
        xfer("rd_last", 1'b1, c_BASE + 32'h3FC, 4'hF, 32'h0, 32'h11223344, 1'b0);
        xfer("rd_w1_kept", 1'b1, c_BASE + 32'h10, 4'hF, 32'h0, 32'hDEADBEAA, 1'b0);

        // Eight back-to-back requests alternating write/read on one word.
        gnts    = 0;
        vals    = 0;
        last_wd = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                check_eq("b2b.opc", 64'(r_opc_o), 64'd0);
                check_eq("b2b.rdata", 64'(r_rdata_o), (i % 2 == 1) ? 64'd0 : 64'(last_wd));
            end
            req_i   = 1'b1;
            wen_i   = (i % 2 == 1);
            add_i   = c_BASE + 32'h40;
            be_i    = 4'hF;
            wdata_i = 32'hA500_0000 | (32'(i) * 32'h0001_0203);
            if (i % 2 == 0) last_wd = wdata_i;
            #1;
            if (gnt_o) gnts++;
            @(negedge clk_i);
            if (r_valid_o) vals++;
        end
        req_i = 1'b0;
        check_eq("b2b.last_rdata", 64'(r_rdata_o), 64'(last_wd));
        check_eq("b2b.gnts", 64'(gnts), 64'd8);
        check_eq("b2b.valids", 64'(vals), 64'd8);
        @(negedge clk_i);
        check_eq("idle.valid", 64'(r_valid_o), 64'd0);
        check_eq("idle.hold", 64'(r_rdata_o), 64'(last_wd));

        // Clear together with a granted write.
        clear_i = 1'b1;
        xfer("wr_clear", 1'b0, c_BASE + 32'h80, 4'hF, 32'h12345678, 32'h0, 1'b0);
        clear_i = 1'b0;
        check_eq("clear.done", 64'(init_done_o), 64'd0);
        wait_init("init_clr", 64);
        xfer("rd_clr80", 1'b1, c_BASE + 32'h80, 4'hF, 32'h0, 32'h0, 1'b0);
        xfer("rd_clr10", 1'b1, c_BASE + 32'h10, 4'hF, 32'h0, 32'h0, 1'b0);

        // Reset pulse in the middle of INIT.
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_eq("rst_init.done", 64'(init_done_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_init("init_rst1", 64);

        // Reset pulse while a read response is on the bus.
        xfer("wr_cafe", 1'b0, c_BASE + 32'h10, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
        req_i = 1'b1;
        wen_i = 1'b1;
        add_i = c_BASE + 32'h10;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        check_eq("rst_rsp.pre_valid", 64'(r_valid_o), 64'd1);
        check_eq("rst_rsp.pre_rdata", 64'(r_rdata_o), 64'hCAFEF00D);
        rst_ni = 1'b0;
        #1;
        check_eq("rst_rsp.valid", 64'(r_valid_o),   64'd0);
        check_eq("rst_rsp.rdata", 64'(r_rdata_o),   64'd0);
        check_eq("rst_rsp.opc",   64'(r_opc_o),     64'd0);
        check_eq("rst_rsp.done",  64'(init_done_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_init("init_rst2", 64);
        xfer("rd_after_rst", 1'b1, c_BASE + 32'h10, 4'hF, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
